// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes 11-bit frames and
// turns scan-code set 2 make/break sequences into held w/a/s/d/enter levels.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       w,
  output logic       a,
  output logic       s,
  output logic       d,
  output logic       enter,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

  // Frame handshake: byte_valid and frame_error are single-cycle strobes with
  // no ready; byte_data is only meaningful with byte_valid and holds until the next one.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning (idle lines are high, so reset the chain to 1)
  // ---------------------------------------------------------------------------
  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic           clk_filt;
  logic [FCW-1:0] filt_cnt;
  logic           flip;
  logic           fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // The FILTER_LEN-th consecutive differing sample flips the filtered clock.
  assign flip = (clk_s2 != clk_filt) && (filt_cnt == F_LAST);
  assign fall = flip && clk_filt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (flip) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  frame_state_t   state, state_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic [2:0]     bit_cnt, bit_cnt_nxt;
  logic           par_bit, par_nxt;
  logic [TCW-1:0] tmo_cnt, tmo_nxt;
  logic           bv_nxt, fe_nxt;
  logic           tmo_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_bit <= par_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  assign tmo_hit = (tmo_cnt == T_LAST) && !fall;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par_bit;
    tmo_nxt     = tmo_cnt;
    bv_nxt      = 1'b0;
    fe_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        tmo_nxt = '0;
        if (fall && !dat_s2) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = 3'd0;
          shreg_nxt   = 8'h00;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_nxt   = {dat_s2, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_nxt   = dat_s2;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_nxt = ST_IDLE;
          if (dat_s2 && (^{shreg, par_bit})) bv_nxt = 1'b1;
          else                               fe_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A stalled frame is abandoned; a fall on the same cycle wins over the timeout.
    if (state != ST_IDLE) begin
      if (fall) begin
        tmo_nxt = '0;
      end else if (tmo_hit) begin
        state_nxt   = ST_IDLE;
        fe_nxt      = 1'b1;
        bv_nxt      = 1'b0;
        tmo_nxt     = '0;
        bit_cnt_nxt = 3'd0;
        shreg_nxt   = 8'h00;
      end else begin
        tmo_nxt = tmo_cnt + TCW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      byte_data   <= 8'h00;
    end else begin
      byte_valid  <= bv_nxt;
      frame_error <= fe_nxt;
      if (bv_nxt) byte_data <= shreg;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code decode: E0 / F0 prefixes, then a key lookup
  // ---------------------------------------------------------------------------
  logic       ext, brk;
  logic [4:0] keys;       // {enter, d, s, a, w}
  logic       key_hit;
  logic [2:0] key_idx;

  always_comb begin
    key_hit = 1'b1;
    key_idx = 3'd0;
    case ({ext, byte_data})
      9'h01D, 9'h175: key_idx = 3'd0;
      9'h01C, 9'h16B: key_idx = 3'd1;
      9'h01B, 9'h172: key_idx = 3'd2;
      9'h023, 9'h174: key_idx = 3'd3;
      9'h05A, 9'h15A: key_idx = 3'd4;
      default:        key_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      keys <= 5'b00000;
    end else if (frame_error) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      case (byte_data)
        8'hE0:   ext <= 1'b1;
        8'hF0:   brk <= 1'b1;
        default: begin
          if (key_hit) keys[key_idx] <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

  assign w     = keys[0];
  assign a     = keys[1];
  assign s     = keys[2];
  assign d     = keys[3];
  assign enter = keys[4];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: PS/2 frame driver, event scoreboard and a
// table-driven key-level model checked every cycle.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;

  localparam logic [7:0] PLAIN_CODES [5] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h5A};
  localparam logic [7:0] EXT_CODES   [5] = '{8'h75, 8'h6B, 8'h72, 8'h74, 8'h5A};

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_dat;
  logic       w, a, s, d, enter, byte_valid, frame_error;
  logic [7:0] byte_data;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .w(w), .a(a), .s(s), .d(d), .enter(enter),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_error(frame_error)
  );

  // ---------------- scoreboard and model ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];        // bit 8 = frame error expected, [7:0] = byte
  logic [4:0] m_keys = 5'b0;   // {enter, d, s, a, w}
  bit         m_ext  = 1'b0;
  bit         m_brk  = 1'b0;
  int         ev_count = 0;
  int         bv_cyc = 0;
  int         w_rise_cyc = 0;
  int         last_fall_cyc = 0;
  logic       w_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      for (int i = 0; i < 5; i++)
        if ((m_ext ? EXT_CODES[i] : PLAIN_CODES[i]) == b) m_keys[i] = ~m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  always @(negedge clock) begin
    logic [8:0] e;
    if (reset) begin
      check("reset_outputs", {24'h0, w, a, s, d, enter, byte_valid, frame_error, byte_data}, 32'h0);
      w_prev = 1'b0;
    end else begin
      check("key_levels", {27'h0, enter, d, s, a, w}, {27'h0, m_keys});
      check("bv_fe_exclusive", {31'h0, byte_valid & frame_error}, 32'h0);
      if (w && !w_prev) w_rise_cyc = cyc;
      w_prev = w;
      if (byte_valid || frame_error) begin
        ev_count++;
        if (byte_valid) bv_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got bv=%0b fe=%0b data=%0h expected no event",
                   byte_valid, frame_error, byte_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_event", {23'h0, frame_error, byte_valid ? byte_data : 8'h00}, {23'h0, e});
          if (e[8]) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
          end else begin
            model_byte(e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b, input int half);
    ps2_dat = b;
    tick(half);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    tick(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
    exp_q.push_back((bad_par || bad_stop) ? 9'h100 : {1'b0, b});
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit((~^b) ^ bad_par, half);
    send_bit(~bad_stop, half);
    ps2_dat = 1'b1;
    tick(half + FILTER_LEN + 6);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, FILTER_LEN + 4);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 64) begin
      tick(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic glitch();
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(FILTER_LEN + 10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ev0, lat, r, k, half;
    logic [7:0] seq[$];
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(4);
    check("reset_state", {24'h0, w, a, s, d, enter, byte_valid, frame_error, byte_data}, 32'h0);
    reset = 1'b0;
    tick(4);

    // Single make code, with latency checks.
    good(8'h1D);
    drain("drain_1d");
    lat = bv_cyc - last_fall_cyc;
    check("bv_latency_in_range", {31'h0, (lat >= FILTER_LEN + 2) && (lat <= FILTER_LEN + 4)}, 32'h1);
    check("w_one_after_bv", w_rise_cyc - bv_cyc, 1);
    check("byte_data_1d", {24'h0, byte_data}, 32'h1D);
    check("w_make", {27'h0, w, a, s, d, enter}, 32'b10000);

    good(8'hF0); good(8'h1D);
    drain("drain_w_break");
    check("w_break", {27'h0, w, a, s, d, enter}, 32'b00000);

    good(8'hE0); good(8'h75);
    drain("drain_up_make");
    check("up_make", {31'h0, w}, 32'h1);
    good(8'hE0); good(8'hF0); good(8'h75);
    drain("drain_up_break");
    check("up_break", {31'h0, w}, 32'h0);
    good(8'hE0); good(8'h5A);
    drain("drain_kp_enter");
    check("kp_enter_make", {31'h0, enter}, 32'h1);
    good(8'hE0); good(8'hF0); good(8'h5A);
    drain("drain_kp_enter_brk");
    check("kp_enter_break", {31'h0, enter}, 32'h0);

    // Parity error, then a good frame of the same code.
    send_frame(8'h1C, 1'b1, 1'b0, FILTER_LEN + 4);
    drain("drain_bad_par");
    check("a_after_bad_par", {31'h0, a}, 32'h0);
    good(8'h1C);
    drain("drain_a_make");
    check("a_make", {31'h0, a}, 32'h1);
    good(8'hF0); good(8'h1C);
    drain("drain_a_break");

    // Timeout mid-frame: start bit plus four data bits, then silence.
    ev0 = ev_count;
    exp_q.push_back(9'h100);
    send_bit(1'b0, FILTER_LEN + 4);
    for (int i = 0; i < 4; i++) send_bit(1'b1, FILTER_LEN + 4);
    ps2_dat = 1'b1;
    tick(TIMEOUT + 10 + FILTER_LEN);
    drain("drain_timeout");
    check("timeout_one_event", ev_count - ev0, 1);
    good(8'h23);
    drain("drain_d_make");
    check("d_after_timeout", {31'h0, d}, 32'h1);

    // Short glitch on the clock line must not start a frame.
    ev0 = ev_count;
    glitch();
    check("glitch_no_event", ev_count - ev0, 0);
    good(8'hF0); good(8'h23);
    drain("drain_after_glitch");
    check("d_break_after_glitch", {31'h0, d}, 32'h0);

    // Reset mid-frame while W and D are held.
    good(8'h1D); good(8'h23);
    drain("drain_wd");
    check("wd_held", {27'h0, w, a, s, d, enter}, 32'b10010);
    send_bit(1'b0, FILTER_LEN + 4);
    send_bit(1'b1, FILTER_LEN + 4);
    @(posedge clock);
    #3;
    reset  = 1'b1;
    m_keys = 5'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_clears", {25'h0, w, a, s, d, enter, byte_valid, frame_error}, 32'h0);
    ps2_dat = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(5);
    good(8'h1B);
    drain("drain_s_make");
    check("s_only_after_reset", {27'h0, w, a, s, d, enter}, 32'b00100);

    // Randomized key traffic with prefixes, noise, bad frames and glitches.
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      half = $urandom_range(FILTER_LEN + 3, FILTER_LEN + 8);
      seq.delete();
      if (r <= 5) begin
        k = $urandom_range(0, 4);
        if ($urandom_range(0, 1) == 1) begin
          seq.push_back(8'hE0);
          if ($urandom_range(0, 1) == 1) seq.push_back(8'hF0);
          seq.push_back(EXT_CODES[k]);
        end else begin
          if ($urandom_range(0, 1) == 1) seq.push_back(8'hF0);
          seq.push_back(PLAIN_CODES[k]);
        end
        foreach (seq[j])
          send_frame(seq[j], $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, half);
      end else if (r == 6) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, half);
      end else if (r == 7) begin
        glitch();
      end else if (r == 8) begin
        send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 1'b1, half);
      end else begin
        tick($urandom_range(1, 40));
      end
    end
    drain("final_drain");
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
